// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and pipeline-control outputs of the stall/flush scheduler.
// slave = the scheduler itself, master = whoever drives the hazard signals.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             mem_readE;
  logic [4:0]       rt_addrE;
  logic [4:0]       rs_addrD;
  logic [4:0]       rt_addrD;
  logic             pc_src;
  logic             jumpD;
  logic             md_startE;
  logic             md_is_divE;
  logic             md_startD;
  logic             hilo_readD;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_enable;
  logic             instr_enable;
  logic             if_flush;
  logic             control_mux;
  logic             ex_enable;
  logic             wb_enable;
  logic             md_busy;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_count;

  modport slave (
    input  mem_readE, rt_addrE, rs_addrD, rt_addrD, pc_src, jumpD,
           md_startE, md_is_divE, md_startD, hilo_readD, dmem_req, dmem_ready,
    output pc_enable, instr_enable, if_flush, control_mux, ex_enable, wb_enable,
           md_busy, mem_fault, stall_count
  );

  modport master (
    output mem_readE, rt_addrE, rs_addrD, rt_addrD, pc_src, jumpD,
           md_startE, md_is_divE, md_startD, hilo_readD, dmem_req, dmem_ready,
    input  pc_enable, instr_enable, if_flush, control_mux, ex_enable, wb_enable,
           md_busy, mem_fault, stall_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage MIPS pipeline: merges load-use,
// HI/LO and dmem-wait hazards with redirects, tracks mult/div latency and dmem timeouts.
module pipeline_stall_ctrl #(
  parameter int MUL_LAT     = 4,
  parameter int DIV_LAT     = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_stall_ctrl_if.slave bus
);
  localparam int MD_W = $clog2((DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT) + 1;
  localparam int WT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [MD_W-1:0] MD_MUL_LD = MD_W'(MUL_LAT - 1);
  localparam logic [MD_W-1:0] MD_DIV_LD = MD_W'(DIV_LAT - 1);
  localparam logic [WT_W-1:0] WT_LAST   = WT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_FAULT} state_t;

  state_t           r_state, w_state_nxt;
  logic [MD_W-1:0]  r_md_cnt;
  logic [WT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_mem_wait, w_load_use, w_md_busy, w_md_haz, w_timeout;
  logic w_pc_en, w_instr_en, w_ex_en, w_wb_en, w_flush, w_cmux;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_mem_wait = bus.dmem_req & ~bus.dmem_ready;
  assign w_load_use = bus.mem_readE & (bus.rt_addrE != 5'd0) &
                      ((bus.rt_addrE == bus.rs_addrD) | (bus.rt_addrE == bus.rt_addrD));
  assign w_md_busy  = (r_md_cnt != '0);
  assign w_md_haz   = (w_md_busy | bus.md_startE) & (bus.hilo_readD | bus.md_startD);
  assign w_timeout  = w_mem_wait & (r_wait_cnt == WT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // Priority chain: fault > mem freeze > ID stall > redirect flush.
  // A redirect blocked by a stall simply re-presents once ID is released.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_en     = 1'b1;
    w_instr_en  = 1'b1;
    w_ex_en     = 1'b1;
    w_wb_en     = 1'b1;
    w_flush     = 1'b0;
    w_cmux      = 1'b1;
    case (r_state)
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = w_mem_wait ? (w_timeout ? S_FAULT : S_MEM_WAIT) : S_RUN;
    endcase
    if (reset || r_state == S_FAULT || w_mem_wait) begin
      w_pc_en    = 1'b0;
      w_instr_en = 1'b0;
      w_ex_en    = 1'b0;
      w_wb_en    = 1'b0;
    end else if (w_load_use || w_md_haz) begin
      w_pc_en    = 1'b0;
      w_instr_en = 1'b0;
      w_cmux     = 1'b0;
    end else if (bus.pc_src || bus.jumpD) begin
      w_flush    = 1'b1;
    end
  end

  // Counters: dmem wait run length, mult/div countdown, stall statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt  <= '0;
      r_md_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_state != S_FAULT)
        r_wait_cnt <= w_mem_wait ? r_wait_cnt + WT_W'(1) : '0;
      if (bus.md_startE && w_ex_en)
        r_md_cnt <= bus.md_is_divE ? MD_DIV_LD : MD_MUL_LD;
      else if (w_md_busy)
        r_md_cnt <= r_md_cnt - MD_W'(1);
      if (!w_pc_en && r_state != S_FAULT)
        r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign bus.pc_enable    = w_pc_en;
  assign bus.instr_enable = w_instr_en;
  assign bus.ex_enable    = w_ex_en;
  assign bus.wb_enable    = w_wb_en;
  assign bus.if_flush     = w_flush;
  assign bus.control_mux  = w_cmux;
  assign bus.md_busy      = w_md_busy & ~reset;
  assign bus.mem_fault    = (r_state == S_FAULT);
  assign bus.stall_count  = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomised + directed bench for pipeline_stall_ctrl against a cycle-time reference model.
module tb_pipeline_stall_ctrl;
  localparam int ML = 4, DL = 32, TO = 8, CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  pipeline_stall_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_stall_ctrl #(.MUL_LAT(ML), .DIV_LAT(DL), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  // Model: absolute cycle number, cycle at which mult/div result is ready,
  // consecutive dmem-wait cycles seen, total stall cycles, fault flag.
  int cyc = 0, md_ready_at = 0, waits = 0, stalls = 0;
  bit fault = 0;
  bit e_pc, e_instr, e_ex, e_wb, e_flush, e_cmux, e_busy, e_fault;
  int e_cnt;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    md_ready_at = 0; waits = 0; stalls = 0; fault = 0;
  endtask

  task automatic compute_expected();
    bit mw, lu, mdh, busy;
    mw   = bus.dmem_req && !bus.dmem_ready;
    busy = !reset && (cyc < md_ready_at);
    lu   = bus.mem_readE && bus.rt_addrE != 0 &&
           (bus.rt_addrE == bus.rs_addrD || bus.rt_addrE == bus.rt_addrD);
    mdh  = (busy || bus.md_startE) && (bus.hilo_readD || bus.md_startD);
    {e_pc, e_instr, e_ex, e_wb, e_flush, e_cmux} = 6'b111101;
    if (reset || fault || mw) {e_pc, e_instr, e_ex, e_wb} = 4'b0000;
    else if (lu || mdh) {e_pc, e_instr, e_cmux} = 3'b000;
    else if (bus.pc_src || bus.jumpD) e_flush = 1'b1;
    e_busy  = busy;
    e_fault = fault && !reset;
    e_cnt   = (stalls > CNT_MAX) ? CNT_MAX : stalls;
  endtask

  task automatic settle();
    #1;
    compute_expected();
    cmp("pc_enable",    bus.pc_enable,    e_pc);
    cmp("instr_enable", bus.instr_enable, e_instr);
    cmp("ex_enable",    bus.ex_enable,    e_ex);
    cmp("wb_enable",    bus.wb_enable,    e_wb);
    cmp("if_flush",     bus.if_flush,     e_flush);
    cmp("control_mux",  bus.control_mux,  e_cmux);
    cmp("md_busy",      bus.md_busy,      e_busy);
    cmp("mem_fault",    bus.mem_fault,    e_fault);
    cmp("stall_count",  bus.stall_count,  e_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      if (!fault) begin
        if (!e_pc) stalls++;
        if (bus.dmem_req && !bus.dmem_ready) begin
          if (waits == TO - 1) fault = 1;
          waits++;
        end else waits = 0;
      end
      if (bus.md_startE && e_ex) md_ready_at = cyc + (bus.md_is_divE ? DL : ML);
      cyc++;
    end
    #1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic clear_inputs();
    bus.mem_readE = 0; bus.rt_addrE = 0; bus.rs_addrD = 0; bus.rt_addrD = 0;
    bus.pc_src = 0; bus.jumpD = 0; bus.md_startE = 0; bus.md_is_divE = 0;
    bus.md_startD = 0; bus.hilo_readD = 0; bus.dmem_req = 0; bus.dmem_ready = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;

    // 1: mult followed by mfhi stalls MUL_LAT cycles
    bus.md_startE = 1; bus.hilo_readD = 1;
    settle();
    cmp("t1_pc_c0", bus.pc_enable, 1'b0);
    tick();
    bus.md_startE = 0;
    for (int i = 1; i <= 3; i++) begin
      settle();
      cmp("t1_busy_c", bus.md_busy, 1'b1);
      cmp("t1_pc_c", bus.pc_enable, 1'b0);
      tick();
    end
    settle();
    cmp("t1_pc_c4", bus.pc_enable, 1'b1);
    tick();
    clear_inputs();

    // 2: three dmem wait cycles then ready
    pulse_reset();
    bus.dmem_req = 1; bus.dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      cmp("t2_wb_frozen", bus.wb_enable, 1'b0);
      tick();
    end
    bus.dmem_ready = 1;
    settle();
    cmp("t2_ex_resume", bus.ex_enable, 1'b1);
    tick();
    clear_inputs();
    settle();
    cmp("t2_stall_count", bus.stall_count, 3);
    tick();

    // 3: timeout after MEM_TIMEOUT wait cycles, fault sticky
    pulse_reset();
    bus.dmem_req = 1; bus.dmem_ready = 0;
    for (int i = 0; i < TO; i++) begin
      settle();
      cmp("t3_no_fault_yet", bus.mem_fault, 1'b0);
      tick();
    end
    bus.dmem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      cmp("t3_fault", bus.mem_fault, 1'b1);
      cmp("t3_pc", bus.pc_enable, 1'b0);
      tick();
    end
    cmp("t3_count", bus.stall_count, TO);
    clear_inputs();
    pulse_reset();

    // 4: load-use suppresses a coincident branch flush
    bus.mem_readE = 1; bus.rt_addrE = 5; bus.rs_addrD = 5; bus.pc_src = 1;
    settle();
    cmp("t4_pc", bus.pc_enable, 1'b0);
    cmp("t4_cmux", bus.control_mux, 1'b0);
    cmp("t4_flush0", bus.if_flush, 1'b0);
    tick();
    bus.mem_readE = 0;
    settle();
    cmp("t4_flush1", bus.if_flush, 1'b1);
    tick();
    clear_inputs();

    // 5: async reset with a divide in flight
    pulse_reset();
    bus.md_startE = 1; bus.md_is_divE = 1;
    cycle();
    bus.md_startE = 0; bus.md_is_divE = 0; bus.hilo_readD = 1;
    for (int i = 0; i < 11; i++) cycle();
    settle();
    cmp("t5_busy_before", bus.md_busy, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    cmp("t5_busy_async", bus.md_busy, 1'b0);
    cmp("t5_count_async", bus.stall_count, 0);
    cmp("t5_fault_async", bus.mem_fault, 1'b0);
    tick();
    clear_inputs();
    reset = 1'b0;

    // 6: stall counter saturation
    bus.mem_readE = 1; bus.rt_addrE = 3; bus.rt_addrD = 3;
    for (int i = 0; i < 20; i++) cycle();
    settle();
    cmp("t6_saturate", bus.stall_count, CNT_MAX);
    tick();
    clear_inputs();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 400 == 0 || $urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        model_reset();
      end else reset = 1'b0;
      bus.mem_readE  = ($urandom_range(0, 2) == 0);
      bus.rt_addrE   = 5'($urandom_range(0, 3));
      bus.rs_addrD   = 5'($urandom_range(0, 3));
      bus.rt_addrD   = 5'($urandom_range(0, 3));
      bus.pc_src     = ($urandom_range(0, 3) == 0);
      bus.jumpD      = ($urandom_range(0, 7) == 0);
      bus.md_startE  = ($urandom_range(0, 7) == 0);
      bus.md_is_divE = ($urandom_range(0, 2) == 0);
      bus.md_startD  = ($urandom_range(0, 7) == 0);
      bus.hilo_readD = ($urandom_range(0, 5) == 0);
      bus.dmem_req   = ($urandom_range(0, 2) == 0);
      bus.dmem_ready = (n % 400 > 300 && n % 400 < 320) ? 1'b0 : ($urandom_range(0, 3) != 0);
      cycle();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
